// File: rtl/tt_um_ro_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of an async divided-osc line over a clk gate window.
// Define FREQ_METER_PERIOD_EN to also build period mode (clk cycles between two osc edges).
module tt_um_ro_freq_meter #(
  parameter int GATE_CYCLES = 10000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int WIN_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef FREQ_METER_PERIOD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, LATCH = 2'd2, ARM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, LATCH = 2'd2} state_t;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t             state, state_nxt;
  logic               osc_p0, osc_p1, osc_p2;
  logic               start_p0, start_p1, start_p2;
  logic               osc_pulse, start_pulse;
  logic [WIN_W-1:0]   win;
  logic [CNT_W-1:0]   edge_cnt;
  logic               sat;
  logic [CNT_W-1:0]   result;
  logic               ovf;
  logic               valid;
  logic [CNT_W-9:0]   shadow;
  logic               busy;
  logic               period_mode;
  logic               unused;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synchronized value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      osc_p0   <= 1'b0;
      osc_p1   <= 1'b0;
      osc_p2   <= 1'b0;
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
    end else begin
      osc_p0   <= ui_in[0];
      osc_p1   <= osc_p0;
      osc_p2   <= osc_p1;
      start_p0 <= ui_in[2];
      start_p1 <= start_p0;
      start_p2 <= start_p1;
    end
  end

  assign osc_pulse   = osc_p1 & ~osc_p2;
  assign start_pulse = start_p1 & ~start_p2;

`ifdef FREQ_METER_PERIOD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_mode <= 1'b0;
    end else if (state == IDLE) begin
      period_mode <= ui_in[4];
    end
  end
  assign unused = &{1'b0, ena, uio_in, ui_in[7:5]};
`else
  assign period_mode = 1'b0;
  assign unused      = &{1'b0, ena, uio_in, ui_in[7:4]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_pulse || ui_in[3]) begin
          state_nxt = GATE;
`ifdef FREQ_METER_PERIOD_EN
          if (ui_in[4]) state_nxt = ARM;
`endif
        end
      end
`ifdef FREQ_METER_PERIOD_EN
      ARM: begin
        if (osc_pulse) state_nxt = GATE;
      end
`endif
      GATE: begin
        if (period_mode) begin
          // the closing edge ends the period; a full counter ends it as overflow
          if (osc_pulse || edge_cnt == CNT_MAX) state_nxt = LATCH;
        end else if (win == WIN_LAST) begin
          state_nxt = LATCH;
        end
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage gate: window and edge counters, cleared whenever the FSM sits in IDLE
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        win      <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end
      GATE: begin
        win <= win + 1'b1;
        if (period_mode) begin
          edge_cnt <= sat_inc(edge_cnt);
          if (edge_cnt == CNT_MAX && !osc_pulse) sat <= 1'b1;
        end else if (osc_pulse) begin
          edge_cnt <= sat_inc(edge_cnt);
          if (edge_cnt == CNT_MAX) sat <= 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage latch: result/ovf only move in LATCH so a readout never sees a partial count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else if (state == LATCH) begin
      result <= edge_cnt;
      ovf    <= sat;
      valid  <= 1'b1;
    end
  end

  // Stage readout: a low-byte read snapshots the high bits so the following high read matches it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_out <= 8'h00;
      shadow <= '0;
    end else if (!ui_in[1]) begin
      uo_out <= result[7:0];
      shadow <= result[CNT_W-1:8];
    end else begin
      uo_out <= 8'(shadow);
    end
  end

  assign busy    = (state != IDLE);
  assign uio_out = {4'b0000, osc_p1, busy, ovf, valid};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_ro_freq_meter.sv
// Randomized-osc bench for tt_um_ro_freq_meter; expected counts come from a log of pin rise times.
module tb_tt_um_ro_freq_meter;

  localparam int G    = 1100;
  localparam int W    = 9;
  localparam int MAXC = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       osc = 1'b0, sel = 1'b0, start = 1'b0, cont = 1'b0, pmode = 1'b0;
  logic [2:0] spare = 3'b000;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {spare, pmode, cont, start, sel, osc};

  tt_um_ro_freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   osc_period = 0;
  int   osc_ph = 0;
  logic osc_hold = 1'b0;
  int   rises[$];
  int   pulse_at[$];

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    logic nv;
    @(negedge clk);
    if (osc_period > 0) begin
      osc_ph = (osc_ph + 1) % osc_period;
      nv = (osc_ph < osc_period / 2);
    end else begin
      nv = osc_hold;
      foreach (pulse_at[i]) if (pulse_at[i] == cyc) nv = 1'b1;
    end
    if (nv && !osc) rises.push_back(cyc);
    osc = nv;
  endtask

  task automatic set_osc(input int p);
    osc_period = p;
    osc_ph = (p > 0) ? int'($urandom_range(0, p - 1)) : 0;
  endtask

  // A pin rise at cycle t is acted on at edge t+3; a window whose first GATE edge is e spans G edges.
  function automatic int win_count(input int e);
    int n = 0;
    foreach (rises[i]) if (rises[i] + 3 >= e && rises[i] + 3 <= e + G - 1) n++;
    return n;
  endfunction

  task automatic measure(input string tag, input int restart_at, input int sched);
    int s, n, cnt, expv;
    sel = 1'b0;
    pulse_at.delete();
    if (sched == 1) begin
      pulse_at.push_back(cyc + 2);
      pulse_at.push_back(cyc + 1 + G);
    end else if (sched == 2) begin
      pulse_at.push_back(cyc + 1);
      pulse_at.push_back(cyc + 1 + G + 1);
    end
    tick();
    start = 1'b1;
    s = cyc;
    tick(); tick();
    chk({tag, "_busy_early"}, int'(uio_out[2]), 0);
    tick();
    start = 1'b0;
    chk({tag, "_busy_rise"}, int'(uio_out[2]), 1);
    n = 1;
    for (int k = 0; k < G + 20; k++) begin
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 3) start = 1'b0;
      tick();
      if (!uio_out[2]) break;
      n++;
    end
    chk({tag, "_busy_len"}, n, G + 1);
    cnt  = win_count(s + 4);
    expv = (cnt > MAXC) ? MAXC : cnt;
    tick();
    chk({tag, "_low"}, int'(uo_out), expv & 255);
    sel = 1'b1;
    tick();
    chk({tag, "_high"}, int'(uo_out), expv >> 8);
    sel = 1'b0;
    chk({tag, "_valid"}, int'(uio_out[0]), 1);
    chk({tag, "_ovf"}, int'(uio_out[1]), (cnt > MAXC) ? 1 : 0);
    pulse_at.delete();
  endtask

  initial begin
    int c, e0, e1, e2, r1, r2, r3, n, s, q1, q2;

    // reset with random inputs
    osc_hold = 1'(($urandom & 1));
    {spare, pmode, cont, start, sel} = 7'($urandom);
    uio_in = 8'($urandom);
    tick(); tick();
    chk("rst_uo_out", int'(uo_out), 0);
    chk("rst_uio_out", int'(uio_out), 0);
    chk("rst_uio_oe", int'(uio_oe), 8'h0F);
    {spare, pmode, cont, start, sel} = 7'd0;
    osc_hold = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_busy_after", int'(uio_out[2]), 0);

    // synchronized osc monitor
    osc_hold = 1'b1;
    repeat (3) tick();
    chk("mon_high", int'(uio_out[3]), 1);
    osc_hold = 1'b0;
    repeat (3) tick();
    chk("mon_low", int'(uio_out[3]), 0);
    chk("uio_upper_zero", int'(uio_out[7:4]), 0);

    set_osc(10);
    repeat (10) tick();
    measure("freq_p10", 0, 0);

    set_osc(0);
    repeat (5) tick();
    measure("edge_inside", 0, 1);
    measure("edge_outside", 0, 2);

    set_osc(2);
    repeat (5) tick();
    measure("sat_p2", 0, 0);

    // reset 50 cycles into a window
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", int'(uio_out[2]), 0);
    chk("midrst_valid", int'(uio_out[0]), 0);
    chk("midrst_ovf", int'(uio_out[1]), 0);
    chk("midrst_uo", int'(uo_out), 0);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < G + 20; k++) begin
      tick();
      if (uio_out[2]) n++;
    end
    chk("midrst_no_latch", n, 0);
    chk("midrst_result", int'(uo_out), 0);
    chk("midrst_valid_late", int'(uio_out[0]), 0);

    set_osc(4);
    repeat (6) tick();
    measure("freq_p4", 0, 0);

    set_osc(int'($urandom_range(3, 12)));
    repeat (6) tick();
    measure("freq_rand_a", 300, 0);
    set_osc(int'($urandom_range(3, 12)));
    repeat (6) tick();
    measure("freq_rand_b", 0, 0);

    // continuous mode and tear-free readout across a LATCH
    set_osc(4);
    repeat (8) tick();
    cont = 1'b1;
    c = cyc;
    tick();
    chk("cont_busy_w1", int'(uio_out[2]), 1);
    e0 = c + 2;
    while (cyc < e0 + G - 1) tick();
    chk("cont_busy_latch1", int'(uio_out[2]), 1);
    tick();
    chk("cont_idle_gap", int'(uio_out[2]), 0);
    tick();
    chk("cont_busy_w2", int'(uio_out[2]), 1);
    r1 = win_count(e0);
    if (r1 > MAXC) r1 = MAXC;
    chk("cont_w1_low", int'(uo_out), r1 & 255);
    set_osc(10);
    e1 = e0 + G + 2;
    while (cyc < e1 + G - 1) tick();
    tick();
    chk("cont_snap_low", int'(uo_out), r1 & 255);
    sel = 1'b1;
    tick();
    chk("cont_snap_high", int'(uo_out), r1 >> 8);
    sel = 1'b0;
    tick();
    r2 = win_count(e1);
    if (r2 > MAXC) r2 = MAXC;
    chk("cont_w2_low", int'(uo_out), r2 & 255);
    cont = 1'b0;
    e2 = e1 + G + 2;
    while (cyc < e2 + G) tick();
    chk("cont_stop_idle", int'(uio_out[2]), 0);
    tick();
    r3 = win_count(e2);
    if (r3 > MAXC) r3 = MAXC;
    chk("cont_w3_low", int'(uo_out), r3 & 255);
    n = 0;
    for (int k = 0; k < G + 10; k++) begin
      tick();
      if (uio_out[2]) n++;
    end
    chk("cont_stopped", n, 0);

`ifdef FREQ_METER_PERIOD_EN
    set_osc(37);
    repeat (5) tick();
    pmode = 1'b1;
    start = 1'b1;
    s = cyc;
    tick(); tick(); tick();
    start = 1'b0;
    pmode = 1'b0;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!uio_out[2]) break;
      n++;
    end
    chk("per_done", (n < 400) ? 1 : 0, 1);
    q1 = -1;
    q2 = -1;
    foreach (rises[i]) begin
      if (rises[i] >= s + 1) begin
        if (q1 < 0) q1 = rises[i];
        else if (q2 < 0) q2 = rises[i];
      end
    end
    tick();
    chk("per_p37_low", int'(uo_out), (q2 - q1) & 255);
    chk("per_p37_ovf", int'(uio_out[1]), 0);
    set_osc(0);
    osc_hold = 1'b0;
    repeat (5) tick();
    pmode = 1'b1;
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    pmode = 1'b0;
    repeat (200) tick();
    chk("per_arm_hold", int'(uio_out[2]), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("per_arm_reset", int'(uio_out[2]), 0);
`else
    set_osc(37);
    repeat (5) tick();
    pmode = 1'b1;
    measure("pmode_ignored", 0, 0);
    pmode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_um_ro_freq_meter.md
# tt_um_ro_freq_meter

Frequency/period meter that sits at the receiving end of the on-chip ring-oscillator ripple-divider outputs. It takes one asynchronous divided-oscillator line and counts its rising edges over a fixed window of system clocks. It latches the count as a coherent multi-byte result and reads it out through the dedicated outputs. It lets a bench or host characterise oscillator frequency against `clk`.

## Interface
- `GATE_CYCLES`, default 10000: gate-window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge/result counter; 9..16.
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `ena`  input  1  design-enable; ignored.
- `ui_in`  input  8  [0] osc input (async); [1] byte select (0 = low byte, 1 = high byte); [2] start (rising edge = one measurement); [3] continuous mode; [4] period mode (macro-gated); [7:5] unused.
- `uo_out`  output  8  selected result byte.
- `uio_in`  input  8  unused.
- `uio_out`  output  8  [0] valid, [1] ovf, [2] busy, [3] synchronized osc monitor, [7:4] = 0.
- `uio_oe`  output  8  constant 8'h0F.

## Operation
- `ui_in[0]` and `ui_in[2]` each pass through a 2-FF synchronizer, then a rising-edge detector. The detector is a registered previous value; a pulse occurs when the synchronized value is 1 and the previous value is 0.
- FSM states: IDLE, GATE, LATCH, plus ARM when period mode is compiled in.
- IDLE:
  - Window counter and edge counter are cleared.
  - Go to GATE on a start pulse, or when `ui_in[3]` = 1.
- GATE:
  - Window counter increments every cycle.
  - Edge counter increments on each osc edge pulse. It saturates at 2^CNT_W−1.
  - An edge pulse arriving at saturation sets the internal sat flag.
  - Go to LATCH after exactly GATE_CYCLES cycles in GATE.
- LATCH (1 cycle):
  - result ← edge counter; ovf ← sat.
  - valid ← 1.
  - Return to IDLE.
- busy = 1 in GATE, ARM and LATCH.
- Start pulses outside IDLE are ignored.
- valid stays 1 after the first measurement, until reset.
- result and ovf change only in LATCH.
- Byte readout:
  - While `ui_in[1]` = 0, `uo_out` = result[7:0]. Each of these cycles also captures result[CNT_W-1:8] into a shadow register.
  - While `ui_in[1]` = 1, `uo_out` = shadow, zero-extended.
  - Reading low byte then high byte is therefore tear-free.
- `uo_out` is registered: it reflects select and result one cycle later.

## Timing
- Reset values:
  - `uo_out` = 0, `uio_out` = 0, result = 0, shadow = 0.
  - FSM = IDLE; synchronizers = 0.
- Reset asserted mid-measurement aborts to IDLE the same edge. valid and ovf are cleared.
- An osc edge at the pin produces an edge pulse 3 `clk` edges later. A `ui_in[2]` edge is delayed identically.
- Start pulse in cycle N → GATE in cycles N+1..N+GATE_CYCLES → LATCH at N+GATE_CYCLES+1 → new result/valid visible at N+GATE_CYCLES+2.
- Continuous mode:
  - One IDLE cycle separates windows, so the measurement period is GATE_CYCLES+2.
  - Clearing `ui_in[3]` mid-window finishes the current window.
- Maximum countable osc rate is `clk`/2. Faster inputs alias, and that aliasing is not flagged.
- An edge pulse in the final GATE cycle is counted. A pulse in the LATCH cycle is not.

## Configuration
- `FREQ_METER_PERIOD_EN` defined: period mode is available when `ui_in[4]` = 1 at the IDLE exit.
  - IDLE → ARM; wait for an osc edge pulse.
  - Then GATE counts `clk` cycles until the next osc edge pulse, including the cycle of that pulse.
  - Then LATCH.
  - If the counter saturates before the next edge, go to LATCH with ovf = 1.
  - ARM has no timeout; it exits only on an edge pulse or reset.
- `FREQ_METER_PERIOD_EN` undefined: `ui_in[4]` is ignored, the ARM state does not exist, and only frequency mode is built.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with random `ui_in` → `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'h0F, busy = 0.
- Single frequency measurement:
  - Setup: GATE_CYCLES = 100, osc period 10 `clk`.
  - Stimulus: one start pulse.
  - Expected: busy for 101 cycles, then valid = 1, result = 10 (±1), ovf = 0; low byte 10, high byte 0.
- Saturation:
  - Setup: CNT_W = 9, GATE_CYCLES = 2000, osc period 2 `clk`.
  - Expected: result = 511, ovf = 1.
  - Follow-up: repeat with osc period 8 → result 250, ovf = 0.
- Continuous and coherent readout:
  - Setup: `ui_in[3]` = 1, GATE_CYCLES = 100.
  - Expected: LATCH every 102 cycles.
  - Readout check: select low, then high across a LATCH → high byte matches the low-byte snapshot.
- Reset mid-GATE: assert `rst_n` = 0 at cycle 50 of a window → next cycle IDLE, valid = 0, result = 0; no LATCH occurs.
- Period mode:
  - With macro: osc period 37 `clk`, `ui_in[4]` = 1 → result = 37.
  - With macro, osc held low → stays in ARM, busy = 1.
  - Without macro: same stimulus yields frequency-mode results.
